// File: rtl/icc_branch_unit_pkg.sv
// Shared definitions for the integer condition code consumer: Bicc cond
// encodings, icc bit positions and the delay-slot FSM state type.
package icc_branch_unit_pkg;

   localparam int unsigned ICC_W  = 4;
   localparam int unsigned COND_W = 4;

   // Bit positions inside the {N,Z,V,C} condition code vector
   localparam int unsigned ICC_N = 3;
   localparam int unsigned ICC_Z = 2;
   localparam int unsigned ICC_V = 1;
   localparam int unsigned ICC_C = 0;

   typedef enum logic [COND_W-1:0] {
      COND_BN   = 4'b0000,
      COND_BE   = 4'b0001,
      COND_BLE  = 4'b0010,
      COND_BL   = 4'b0011,
      COND_BLEU = 4'b0100,
      COND_BCS  = 4'b0101,
      COND_BNEG = 4'b0110,
      COND_BVS  = 4'b0111,
      COND_BA   = 4'b1000,
      COND_BNE  = 4'b1001,
      COND_BG   = 4'b1010,
      COND_BGE  = 4'b1011,
      COND_BGU  = 4'b1100,
      COND_BCC  = 4'b1101,
      COND_BPOS = 4'b1110,
      COND_BVC  = 4'b1111
   } cond_e;

   // IDLE: no pending slot; SLOT: next valid instr is a live delay slot;
   // ANNUL: next valid instr is an annulled delay slot
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SLOT  = 2'd1,
      ST_ANNUL = 2'd2
   } state_e;

endpackage

// File: rtl/icc_cond_eval.sv
// Combinational Bicc condition evaluator; also intended for a Ticc trap unit.
module icc_cond_eval
   import icc_branch_unit_pkg::*;
(
   input  logic [ICC_W-1:0]  icc,
   input  logic [COND_W-1:0] cond,
   output logic              t_c
);

   logic n, z, v, c;

   assign n = icc[ICC_N];
   assign z = icc[ICC_Z];
   assign v = icc[ICC_V];
   assign c = icc[ICC_C];

   // Decode the condition field against the flags
   always_comb begin
      t_c = 1'b0;
      case (cond)
         COND_BN:   t_c = 1'b0;
         COND_BE:   t_c = z;
         COND_BLE:  t_c = z | (n ^ v);
         COND_BL:   t_c = n ^ v;
         COND_BLEU: t_c = c | z;
         COND_BCS:  t_c = c;
         COND_BNEG: t_c = n;
         COND_BVS:  t_c = v;
         COND_BA:   t_c = 1'b1;
         COND_BNE:  t_c = ~z;
         COND_BG:   t_c = ~(z | (n ^ v));
         COND_BGE:  t_c = ~(n ^ v);
         COND_BGU:  t_c = ~(c | z);
         COND_BCC:  t_c = ~c;
         COND_BPOS: t_c = ~n;
         COND_BVC:  t_c = ~v;
         default:   t_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/icc_branch_unit.sv
// icc register, Bicc resolution and delay-slot / annul tracking.
module icc_branch_unit
   import icc_branch_unit_pkg::*;
(
   input  logic              Clk,
   input  logic              Clr,
   input  logic              cc_we,
   input  logic [ICC_W-1:0]  cc_in,
   input  logic              instr_valid,
   input  logic              br_valid,
   input  logic [COND_W-1:0] br_cond,
   input  logic              br_a,
   output logic [ICC_W-1:0]  icc,
   output logic              take,
   output logic              resolved,
   output logic              squash,
   output logic              in_slot
);

   state_e           state_q, state_d;
   logic [ICC_W-1:0] icc_q, icc_d;
   logic             take_q, take_d;
   logic             resolved_q, resolved_d;
   logic             t_c;

   // Branches always see the registered icc, never the value being written
   icc_cond_eval u_cond_eval (
      .icc  (icc_q),
      .cond (br_cond),
      .t_c  (t_c)
   );

   // Next-state, icc load and resolution pulses
   always_comb begin
      state_d    = state_q;
      icc_d      = icc_q;
      take_d     = 1'b0;
      resolved_d = 1'b0;

      if (cc_we) begin
         icc_d = cc_in;
      end

      if (instr_valid) begin
         case (state_q)
            ST_IDLE, ST_SLOT: begin
               if (br_valid) begin
                  take_d     = t_c;
                  resolved_d = 1'b1;
                  // Annul applies when not taken, or always for BA
                  if (br_a && (!t_c || (br_cond == COND_BA))) begin
                     state_d = ST_ANNUL;
                  end else begin
                     state_d = ST_SLOT;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ANNUL: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q    <= ST_IDLE;
         icc_q      <= '0;
         take_q     <= 1'b0;
         resolved_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         icc_q      <= icc_d;
         take_q     <= take_d;
         resolved_q <= resolved_d;
      end
   end

   assign icc      = icc_q;
   assign take     = take_q;
   assign resolved = resolved_q;
   assign squash   = (state_q == ST_ANNUL) & instr_valid;
   assign in_slot  = (state_q != ST_IDLE) & instr_valid;

endmodule

// File: tb/tb_icc_branch_unit.sv
// Self-checking bench for icc_branch_unit: directed table, corner sequences,
// exhaustive condition sweep and randomized traffic against a reference model.
module tb_icc_branch_unit;

   logic       Clk = 1'b0;
   logic       Clr;
   logic       cc_we;
   logic [3:0] cc_in;
   logic       instr_valid;
   logic       br_valid;
   logic [3:0] br_cond;
   logic       br_a;
   logic [3:0] icc;
   logic       take;
   logic       resolved;
   logic       squash;
   logic       in_slot;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [3:0] m_icc;
   bit         m_slot;   // next valid instr is a live delay slot
   bit         m_annul;  // next valid instr is an annulled delay slot
   bit         m_take;
   bit         m_res;

   icc_branch_unit dut (
      .Clk         (Clk),
      .Clr         (Clr),
      .cc_we       (cc_we),
      .cc_in       (cc_in),
      .instr_valid (instr_valid),
      .br_valid    (br_valid),
      .br_cond     (br_cond),
      .br_a        (br_a),
      .icc         (icc),
      .take        (take),
      .resolved    (resolved),
      .squash      (squash),
      .in_slot     (in_slot)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Conditions come in complementary pairs: upper half negates lower half
   function automatic bit ref_cond(input logic [3:0] f, input logic [3:0] c);
      bit n, z, v, cy, base;
      n = f[3]; z = f[2]; v = f[1]; cy = f[0];
      case (c[2:0])
         3'd0: base = 1'b0;
         3'd1: base = z;
         3'd2: base = z | (n ^ v);
         3'd3: base = n ^ v;
         3'd4: base = cy | z;
         3'd5: base = cy;
         3'd6: base = n;
         default: base = v;
      endcase
      return base ^ c[3];
   endfunction

   task automatic model_reset();
      m_icc = 4'b0000; m_slot = 0; m_annul = 0; m_take = 0; m_res = 0;
   endtask

   // One clock cycle: drive at negedge, check comb outputs, then registered ones
   task automatic step(input bit we, input logic [3:0] ci, input bit iv, input bit bv,
                       input logic [3:0] cond, input bit a,
                       output logic sq, output logic is, output logic tk,
                       output logic rs, output logic [3:0] ic);
      bit t;
      @(negedge Clk);
      cc_we = we; cc_in = ci; instr_valid = iv; br_valid = bv; br_cond = cond; br_a = a;
      #1;
      sq = squash; is = in_slot;
      chk("squash", {3'b0, squash}, {3'b0, iv & m_annul});
      chk("in_slot", {3'b0, in_slot}, {3'b0, iv & (m_slot | m_annul)});
      t = ref_cond(m_icc, cond);
      m_take = 0; m_res = 0;
      if (iv) begin
         if (m_annul) begin
            m_annul = 0; m_slot = 0;
         end else if (bv) begin
            m_res   = 1;
            m_take  = t;
            m_annul = a & (!t | (cond == 4'b1000));
            m_slot  = !m_annul;
         end else begin
            m_slot = 0;
         end
      end
      if (we) m_icc = ci;
      @(posedge Clk);
      #1;
      tk = take; rs = resolved; ic = icc;
      chk("take", {3'b0, take}, {3'b0, m_take});
      chk("resolved", {3'b0, resolved}, {3'b0, m_res});
      chk("icc", icc, m_icc);
   endtask

   typedef struct {
      bit       we;
      bit [3:0] ci;
      bit       iv;
      bit       bv;
      bit [3:0] cond;
      bit       a;
      bit       e_sq;
      bit       e_is;
      bit       e_tk;
      bit       e_rs;
      bit [3:0] e_icc;
   } vec_t;

   vec_t tbl[17];

   initial begin
      logic sq, is, tk, rs;
      logic [3:0] ic;

      //            we ci      iv bv cond    a  sq is tk rs icc
      tbl[0]  = '{1, 4'b0100, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0100}; // load Z
      tbl[1]  = '{0, 4'b0000, 1, 1, 4'b0001, 0, 0, 0, 1, 1, 4'b0100}; // BE taken
      tbl[2]  = '{0, 4'b0000, 1, 0, 4'b0000, 0, 0, 1, 0, 0, 4'b0100}; // live slot
      tbl[3]  = '{1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000}; // clear icc
      tbl[4]  = '{0, 4'b0000, 1, 1, 4'b0001, 1, 0, 0, 0, 1, 4'b0000}; // BE,a untaken
      tbl[5]  = '{0, 4'b0000, 1, 0, 4'b0000, 0, 1, 1, 0, 0, 4'b0000}; // annulled slot
      tbl[6]  = '{0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000}; // back to idle
      tbl[7]  = '{0, 4'b0000, 1, 1, 4'b1000, 1, 0, 0, 1, 1, 4'b0000}; // BA,a
      tbl[8]  = '{0, 4'b0000, 1, 1, 4'b1000, 0, 1, 1, 0, 0, 4'b0000}; // branch in annulled slot
      tbl[9]  = '{0, 4'b0000, 1, 1, 4'b0000, 1, 0, 0, 0, 1, 4'b0000}; // BN,a
      tbl[10] = '{0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000}; // stall
      tbl[11] = '{0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000}; // stall
      tbl[12] = '{0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000}; // stall
      tbl[13] = '{0, 4'b0000, 1, 0, 4'b0000, 0, 1, 1, 0, 0, 4'b0000}; // annul survives stall
      tbl[14] = '{1, 4'b0100, 1, 1, 4'b0001, 0, 0, 0, 0, 1, 4'b0100}; // BE sees old icc
      tbl[15] = '{0, 4'b0000, 1, 1, 4'b0001, 0, 0, 1, 1, 1, 4'b0100}; // BE in slot, new icc
      tbl[16] = '{0, 4'b0000, 1, 0, 4'b0000, 0, 0, 1, 0, 0, 4'b0100}; // its slot

      // Reset state, with a valid instr applied to the comb outputs
      Clr = 1'b0; cc_we = 0; cc_in = 4'hF; instr_valid = 1; br_valid = 1; br_cond = 4'h8; br_a = 1;
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_icc", icc, 4'b0000);
      chk("rst_take", {3'b0, take}, 4'b0);
      chk("rst_resolved", {3'b0, resolved}, 4'b0);
      chk("rst_squash", {3'b0, squash}, 4'b0);
      chk("rst_in_slot", {3'b0, in_slot}, 4'b0);
      @(negedge Clk);
      instr_valid = 0; br_valid = 0;
      Clr = 1'b1;

      // Directed table
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].we, tbl[i].ci, tbl[i].iv, tbl[i].bv, tbl[i].cond, tbl[i].a, sq, is, tk, rs, ic);
         chk($sformatf("tbl%0d_squash", i), {3'b0, sq}, {3'b0, tbl[i].e_sq});
         chk($sformatf("tbl%0d_in_slot", i), {3'b0, is}, {3'b0, tbl[i].e_is});
         chk($sformatf("tbl%0d_take", i), {3'b0, tk}, {3'b0, tbl[i].e_tk});
         chk($sformatf("tbl%0d_resolved", i), {3'b0, rs}, {3'b0, tbl[i].e_rs});
         chk($sformatf("tbl%0d_icc", i), ic, tbl[i].e_icc);
      end

      // Asynchronous reset while an annulled slot is pending (icc=0100, BNE untaken)
      step(0, 4'b0000, 1, 1, 4'b1001, 1, sq, is, tk, rs, ic);
      chk("pre_rst_resolved", {3'b0, rs}, 4'b0001);
      @(negedge Clk);
      instr_valid = 1; br_valid = 0;
      #1;
      chk("pre_rst_squash", {3'b0, squash}, 4'b0001);
      Clr = 1'b0;
      #1;
      chk("async_squash", {3'b0, squash}, 4'b0);
      chk("async_in_slot", {3'b0, in_slot}, 4'b0);
      chk("async_icc", icc, 4'b0000);
      chk("async_resolved", {3'b0, resolved}, 4'b0);
      @(negedge Clk);
      instr_valid = 0;
      Clr = 1'b1;
      model_reset();
      step(0, 4'b0000, 1, 0, 4'b0000, 0, sq, is, tk, rs, ic);
      chk("post_rst_squash", {3'b0, sq}, 4'b0);

      // Exhaustive conditions against every icc value
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 16; c++) begin
            step(1, 4'(f), 0, 0, 4'b0000, 0, sq, is, tk, rs, ic);
            step(0, 4'b0000, 1, 1, 4'(c), 0, sq, is, tk, rs, ic);
         end
      end

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         step(1'($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom_range(0, 3) != 0),
              1'($urandom), 4'($urandom), 1'($urandom), sq, is, tk, rs, ic);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
